// File: rtl/memlog_pkg.sv
// Shared definitions for the MEMLog capture sequencer: state encodings,
// default BRAM geometry and MEMLog's read latency.
package memlog_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_FULL = 3'd2,
    ST_FULL      = 3'd3,
    ST_RD_ADDR   = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_RD_SEND   = 3'd6
  } state_e;

endpackage

// File: rtl/memlog_seq_addr_cnt.sv
// Log address counter: synchronous clear-to-zero, increment, and a
// terminal-count flag at the last log address.
module memlog_seq_addr_cnt #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_addr,
  output logic         o_tc
);

  logic [W-1:0] addr_d, addr_q;

  always_comb begin
    addr_d = addr_q;
    if (i_clr) begin
      addr_d = '0;
    end else if (i_inc) begin
      addr_d = addr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign o_addr = addr_q;
  assign o_tc   = (addr_q == '1);

endmodule

// File: rtl/memlog_seq.sv
// MEMLog sequencer: arms a capture, waits for full, then streams every log
// word over valid/ready. Optional WAIT_FULL watchdog: MEMLOG_SEQ_TIMEOUT_EN.
module memlog_seq
  import memlog_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BRAM_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_cmd_run,
  input  logic                       i_cmd_read,
  input  logic                       i_mem_full,
  input  logic [BRAM_DATA_WIDTH-1:0] i_log_data,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  output logic [BRAM_DATA_WIDTH-1:0] o_tx_data,
  input  logic                       i_tx_ready,
  output logic                       o_tx_valid,
  output logic [2:0]                 o_state,
  output logic                       o_timeout
);

  // Stream handshake: a word transfers on a rising edge where o_tx_valid and
  // i_tx_ready are both high; o_tx_data/o_tx_valid hold until that edge.

  state_e                     state_d, state_q;
  logic                       run_log_d, run_log_q;
  logic                       read_log_d, read_log_q;
  logic [BRAM_DATA_WIDTH-1:0] tx_data_d, tx_data_q;
  logic                       tx_valid_d, tx_valid_q;
  logic                       addr_clr, addr_inc, addr_tc;
  logic                       tmo_hit, timeout_set, timeout_clr;

  memlog_seq_addr_cnt #(.W(BRAM_ADDR_WIDTH)) u_addr_cnt (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_clr  (addr_clr),
    .i_inc  (addr_inc),
    .o_addr (o_addr_log),
    .o_tc   (addr_tc)
  );

  always_comb begin
    state_d     = state_q;
    run_log_d   = 1'b0;
    read_log_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    addr_clr    = 1'b0;
    addr_inc    = 1'b0;
    timeout_set = 1'b0;
    timeout_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_run) begin
          state_d     = ST_ARM;
          run_log_d   = 1'b1;
          timeout_clr = 1'b1;
        end
      end
      ST_ARM:       state_d = ST_WAIT_FULL;
      ST_WAIT_FULL: begin
        // Full has priority over the watchdog firing on the same cycle.
        if (i_mem_full) begin
          state_d = ST_FULL;
        end else if (tmo_hit) begin
          state_d     = ST_IDLE;
          timeout_set = 1'b1;
        end
      end
      ST_FULL: begin
        // Read beats run so a collision never discards the captured log.
        if (i_cmd_read) begin
          state_d    = ST_RD_ADDR;
          read_log_d = 1'b1;
          addr_clr   = 1'b1;
        end else if (i_cmd_run) begin
          state_d     = ST_ARM;
          run_log_d   = 1'b1;
          timeout_clr = 1'b1;
        end
      end
      ST_RD_ADDR:   state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        tx_data_d  = i_log_data;
        tx_valid_d = 1'b1;
        state_d    = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (i_tx_ready) begin
          tx_valid_d = 1'b0;
          if (addr_tc) begin
            addr_clr = 1'b1;
            state_d  = ST_FULL;
          end else begin
            addr_inc = 1'b1;
            state_d  = ST_RD_ADDR;
          end
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      run_log_q  <= 1'b0;
      read_log_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_log_q  <= run_log_d;
      read_log_q <= read_log_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

`ifdef MEMLOG_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;
  logic             timeout_d, timeout_q;

  // Counter is zero on the first WAIT_FULL cycle, so the limit spans
  // exactly TIMEOUT_CYCLES cycles in that state.
  assign tmo_hit = (state_q == ST_WAIT_FULL) &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT_FULL) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
    timeout_d = timeout_q;
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (timeout_clr) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign o_timeout  = 1'b0;
  assign unused_tmo = timeout_set | timeout_clr | (TIMEOUT_CYCLES == 0);
`endif

  // RD_ADDR -> RD_WAIT dwell is sized for a single-cycle registered MEMLog read.
  logic unused_lat;
  assign unused_lat = (MEM_RD_LATENCY != 1);

  assign o_state    = state_q;
  assign o_run_log  = run_log_q;
  assign o_read_log = read_log_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_memlog_seq.sv
// Directed bench for memlog_seq with a 16-word registered-read MEMLog model.
module tb_memlog_seq;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          i_rst, i_cmd_run, i_cmd_read, i_mem_full, i_tx_ready;
  logic [DW-1:0] i_log_data;
  logic          o_run_log, o_read_log, o_tx_valid, o_timeout;
  logic [AW-1:0] o_addr_log;
  logic [DW-1:0] o_tx_data;
  logic [2:0]    o_state;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  int tests = 0;
  int failed = 0;

  memlog_seq #(
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_cmd_run  (i_cmd_run),
    .i_cmd_read (i_cmd_read),
    .i_mem_full (i_mem_full),
    .i_log_data (i_log_data),
    .o_run_log  (o_run_log),
    .o_read_log (o_read_log),
    .o_addr_log (o_addr_log),
    .o_tx_data  (o_tx_data),
    .i_tx_ready (i_tx_ready),
    .o_tx_valid (o_tx_valid),
    .o_state    (o_state),
    .o_timeout  (o_timeout)
  );

  // clock / reset-independent MEMLog read model
  always #5 clk = ~clk;

  always @(posedge clk) i_log_data <= mem[o_addr_log];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_exp();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ref_mem[i]);
  endtask

  // Waits for one handshake (bounded), scores data and address, consumes it.
  task automatic take_word(input int idx);
    bit got = 0;
    logic [DW-1:0] exp_w;
    for (int n = 0; n < 20 && !got; n++) begin
      if (o_tx_valid && i_tx_ready) begin
        got = 1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk($sformatf("word%0d_data", idx), 32'(o_tx_data), 32'(exp_w));
        chk($sformatf("word%0d_addr", idx), 32'(o_addr_log), 32'(idx));
      end
      step();
    end
    if (!got) chk($sformatf("word%0d_timeout", idx), 0, 1);
  endtask

  task automatic pulse_read();
    i_cmd_read = 1'b1;
    step();
    i_cmd_read = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] held;
    i_rst = 1'b1; i_cmd_run = 1'b0; i_cmd_read = 1'b0;
    i_mem_full = 1'b0; i_tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = DW'($urandom_range(0, 16'hFFFF));
      mem[i] = ref_mem[i];
    end
    step(); step();
    i_rst = 1'b0;
    chk("rst_state", 32'(o_state), 0);
    chk("rst_outs", {o_run_log, o_read_log, o_tx_valid, o_timeout}, 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);

    // read in IDLE is ignored
    pulse_read();
    chk("idle_read_state", 32'(o_state), 0);
    chk("idle_read_outs", {o_run_log, o_read_log, o_tx_valid}, 0);
    chk("idle_read_addr", 32'(o_addr_log), 0);

    // arm and capture
    i_cmd_run = 1'b1;
    step();
    i_cmd_run = 1'b0;
    chk("arm_state", 32'(o_state), 1);
    chk("arm_run_log", 32'(o_run_log), 1);
    step();
    chk("wait_state", 32'(o_state), 2);
    chk("wait_run_log", 32'(o_run_log), 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      i_cmd_read = (i == 10);
      step();
      if (o_run_log || o_state != 3'd2) n++;
    end
    i_cmd_read = 1'b0;
    chk("wait_hold_50", n, 0);
    i_mem_full = 1'b1;
    step();
    chk("full_state", 32'(o_state), 3);

    // full dump, ready always high
    load_exp();
    pulse_read();
    chk("dump1_state", 32'(o_state), 4);
    chk("dump1_read_log", 32'(o_read_log), 1);
    chk("dump1_addr0", 32'(o_addr_log), 0);
    for (int i = 0; i < DEPTH; i++) take_word(i);
    chk("dump1_end_state", 32'(o_state), 3);
    chk("dump1_end_addr", 32'(o_addr_log), 0);
    chk("dump1_end_valid", 32'(o_tx_valid), 0);
    chk("dump1_exp_empty", exp_q.size(), 0);

    // replay with backpressure on word 5
    load_exp();
    pulse_read();
    for (int i = 0; i < 5; i++) take_word(i);
    i_tx_ready = 1'b0;
    n = 0;
    while (!o_tx_valid && n < 10) begin step(); n++; end
    chk("bp_valid_seen", 32'(o_tx_valid), 1);
    held = o_tx_data;
    chk("bp_word5_data", 32'(held), 32'(ref_mem[5]));
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), {o_tx_valid, o_addr_log, o_tx_data},
          {1'b1, AW'(5), held});
    end
    i_tx_ready = 1'b1;
    for (int i = 5; i < DEPTH; i++) take_word(i);
    chk("bp_end_state", 32'(o_state), 3);
    chk("bp_exp_empty", exp_q.size(), 0);

    // run/read collision in FULL: read wins
    load_exp();
    i_cmd_run = 1'b1; i_cmd_read = 1'b1;
    step();
    i_cmd_run = 1'b0; i_cmd_read = 1'b0;
    chk("coll_state", 32'(o_state), 4);
    chk("coll_run_log", 32'(o_run_log), 0);
    chk("coll_read_log", 32'(o_read_log), 1);
    for (int i = 0; i < 9; i++) take_word(i);
    n = 0;
    while (!o_tx_valid && n < 10) begin step(); n++; end
    chk("abort_valid_pre", {o_tx_valid, o_addr_log}, {1'b1, AW'(9)});
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_mem_full = 1'b0;
    chk("abort_state", 32'(o_state), 0);
    chk("abort_outs", {o_run_log, o_read_log, o_tx_valid, o_timeout}, 0);
    chk("abort_addr", 32'(o_addr_log), 0);
    chk("abort_tx_data", 32'(o_tx_data), 0);

    // watchdog
    i_cmd_run = 1'b1;
    step();
    i_cmd_run = 1'b0;
    step();
    n = 0;
    while (o_state == 3'd2 && n < 200) begin n++; step(); end
`ifdef MEMLOG_SEQ_TIMEOUT_EN
    chk("tmo_cycles", n, 100);
    chk("tmo_state", 32'(o_state), 0);
    chk("tmo_flag", 32'(o_timeout), 1);
    pulse_read();
    chk("tmo_flag_read", 32'(o_timeout), 1);
    i_cmd_run = 1'b1;
    step();
    i_cmd_run = 1'b0;
    chk("tmo_clear_state", 32'(o_state), 1);
    chk("tmo_clear_flag", 32'(o_timeout), 0);
`else
    chk("notmo_waits", n, 200);
    chk("notmo_state", 32'(o_state), 2);
    chk("notmo_flag", 32'(o_timeout), 0);
`endif
    i_mem_full = 1'b1;
    step(); step();
    chk("final_full", 32'(o_state), 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
